bp_stream_io_cmd_arbiter: RTL and testbench

- Shares one BedRock IO command/response channel between num_req_p requesters, e.g. the stream NBF loader (req 0) and a host debug bridge (req 1), ahead of the IO NoC link.
- Arbitration is round-robin.
- Outstanding commands are bounded by a credit limit.
- Each in-order IO response is routed back to the requester that issued the matching command, using an internal order FIFO.

---
 rtl/bp_stream_io_cmd_arbiter.sv | 99 +++++++++
 tb/tb_bp_stream_io_cmd_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_io_cmd_arbiter.sv
// bp_stream_io_cmd_arbiter: round-robin, credit-limited sharing of one IO cmd/resp channel with in-order response routing
module bp_stream_io_cmd_arbiter #(
  parameter int paddr_width_p = 40,
  parameter int cce_block_width_p = 512,
  parameter int lce_id_width_p = 4,
  parameter int lce_assoc_p = 8,
  parameter int num_req_p = 2,
  parameter int max_outstanding_p = 8,
  localparam int cce_mem_msg_width_lp = 4 + 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p) + 3 + cce_block_width_p,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      hold_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                      req_cmd_v_i,
  output logic [num_req_p-1:0]                      req_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0]           req_resp_o,
  output logic [num_req_p-1:0]                      req_resp_v_o,
  input  logic [num_req_p-1:0]                      req_resp_ready_i,
  output logic [cce_mem_msg_width_lp-1:0]           io_cmd_o,
  output logic                                      io_cmd_v_o,
  input  logic                                      io_cmd_yumi_i,
  input  logic [cce_mem_msg_width_lp-1:0]           io_resp_i,
  input  logic                                      io_resp_v_i,
  output logic                                      io_resp_ready_o,
  output logic [cnt_width_lp-1:0]                   outstanding_o,
  output logic                                      idle_o,
  output logic                                      err_o
);
  localparam int fifo_aw_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  typedef enum logic {e_idle, e_granted} state_e;
  state_e state_q, state_d;
  logic [id_width_lp-1:0] grant_q, grant_d, ptr_q, ptr_d, winner, head;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic [fifo_aw_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [id_width_lp-1:0] fifo_q [max_outstanding_p];
  logic err_q, err_d;
  logic found, can_grant, push, pop, nonempty, resp_ready;
  always_comb begin
    found = 1'b0;
    winner = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && req_cmd_v_i[(int'(ptr_q) + i) % num_req_p]) begin
        found = 1'b1;
        winner = id_width_lp'((int'(ptr_q) + i) % num_req_p);
      end
    end
  end
  assign nonempty = count_q != '0;
  assign head = fifo_q[rptr_q];
  assign can_grant = !hold_i && (count_q < cnt_width_lp'(max_outstanding_p)) && found;
  assign push = (state_q == e_granted) && io_cmd_yumi_i;
  assign resp_ready = nonempty && req_resp_ready_i[head];
  assign pop = io_resp_v_i && resp_ready;
  always_comb begin
    state_d = (state_q == e_idle) ? (can_grant ? e_granted : e_idle) : (io_cmd_yumi_i ? e_idle : e_granted);
    grant_d = (state_q == e_idle && can_grant) ? winner : grant_q;
    ptr_d = push ? ((grant_q == id_width_lp'(num_req_p - 1)) ? '0 : grant_q + id_width_lp'(1)) : ptr_q;
    count_d = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
    wptr_d = push ? ((wptr_q == fifo_aw_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + fifo_aw_lp'(1)) : wptr_q;
    rptr_d = pop ? ((rptr_q == fifo_aw_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + fifo_aw_lp'(1)) : rptr_q;
    err_d = err_q | (io_resp_v_i & ~nonempty);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      grant_q <= '0;
      ptr_q <= '0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= grant_q;
  end
  assign io_cmd_o = req_cmd_i[int'(grant_q)*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
  assign io_cmd_v_o = reset_n_i && (state_q == e_granted);
  assign req_cmd_yumi_o = (reset_n_i && push) ? (num_req_p'(1) << grant_q) : '0;
  assign req_resp_o = io_resp_i;
  assign req_resp_v_o = (reset_n_i && io_resp_v_i && nonempty) ? (num_req_p'(1) << head) : '0;
  assign io_resp_ready_o = reset_n_i && resp_ready;
  assign outstanding_o = count_q;
  assign idle_o = !reset_n_i || ((state_q == e_idle) && !nonempty);
  assign err_o = err_q;
  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == e_granted && !io_cmd_yumi_i) |=> (req_cmd_v_i[grant_q] && $stable(io_cmd_o)));
endmodule

// File: tb/tb_bp_stream_io_cmd_arbiter.sv
// tb_bp_stream_io_cmd_arbiter: directed self-checking bench for bp_stream_io_cmd_arbiter
module tb_bp_stream_io_cmd_arbiter;
  localparam int N = 2;
  localparam int W = 4 + 4 + 40 + 3 + 4 + 3 + 3 + 512;
  logic clk_i = 1'b0;
  logic reset_n_i, hold_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0] req_cmd_v_i, req_cmd_yumi_o, req_resp_v_o, req_resp_ready_i;
  logic [W-1:0] req_resp_o, io_cmd_o, io_resp_i;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;
  logic [3:0] outstanding_o;
  logic idle_o, err_o;
  int vectors = 0;
  int miscompares = 0;
  int y0, y1;
  bp_stream_io_cmd_arbiter dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .hold_i(hold_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
    .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic set_cmd(input int r, input logic [W-1:0] c);
    req_cmd_i[r*W +: W] = c;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_v"}, io_cmd_v_o, 0);
    chk({tag, "_yumi"}, req_cmd_yumi_o, 0);
    chk({tag, "_resp_v"}, req_resp_v_o, 0);
    chk({tag, "_resp_ready"}, io_resp_ready_o, 0);
    chk({tag, "_idle"}, idle_o, 1);
    chk({tag, "_outstanding"}, outstanding_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask
  task automatic do_reset();
    reset_n_i = 1'b0;
    hold_i = 1'b0;
    req_cmd_v_i = '0;
    io_cmd_yumi_i = 1'b0;
    io_resp_v_i = 1'b0;
    req_resp_ready_i = '1;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset_n_i = 1'b1;
    tick();
    chk("rst_after_idle", idle_o, 1);
  endtask
  task automatic issue(input int r, input logic [W-1:0] c);
    int b = 0;
    set_cmd(r, c);
    req_cmd_v_i[r] = 1'b1;
    while (!io_cmd_v_o && b < 10) begin
      tick();
      b++;
    end
    chk("issue_v", io_cmd_v_o, 1);
    chk("issue_cmd", io_cmd_o, c);
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("issue_yumi", req_cmd_yumi_o, 640'(1) << r);
    tick();
    io_cmd_yumi_i = 1'b0;
    req_cmd_v_i[r] = 1'b0;
  endtask
  task automatic resp(input logic [N-1:0] exp_v, input logic [W-1:0] d);
    io_resp_i = d;
    io_resp_v_i = 1'b1;
    #1;
    chk("resp_v", req_resp_v_o, exp_v);
    chk("resp_ready", io_resp_ready_o, 1);
    chk("resp_data", req_resp_o, d);
    tick();
    io_resp_v_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    req_cmd_i = '0;
    io_resp_i = '0;
    do_reset();
    issue(0, W'(64'h8000_0000));
    chk("t1_out1", outstanding_o, 1);
    issue(0, W'(64'h8000_0008));
    chk("t1_out2", outstanding_o, 2);
    issue(0, W'(64'h8000_0010));
    chk("t1_out3", outstanding_o, 3);
    chk("t1_busy", idle_o, 0);
    resp(2'b01, W'(64'hA0));
    chk("t1_out_pop1", outstanding_o, 2);
    resp(2'b01, W'(64'hA1));
    resp(2'b01, W'(64'hA2));
    chk("t1_out_end", outstanding_o, 0);
    chk("t1_idle_end", idle_o, 1);
    chk("t1_err", err_o, 0);
    do_reset();
    set_cmd(0, W'(64'hC0));
    set_cmd(1, W'(64'hC1));
    req_cmd_v_i = 2'b11;
    io_cmd_yumi_i = 1'b1;
    y0 = 0;
    y1 = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_yumi", req_cmd_yumi_o, (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10));
      if (req_cmd_yumi_o[0]) y0++;
      if (req_cmd_yumi_o[1]) y1++;
      tick();
    end
    chk("rr_count0", y0, 4);
    chk("rr_count1", y1, 4);
    chk("full_out", outstanding_o, 8);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("full_no_v", io_cmd_v_o, 0);
      chk("full_out_hold", outstanding_o, 8);
      tick();
    end
    resp(2'b01, W'(64'hB0));
    #1;
    chk("full_after_pop_v", io_cmd_v_o, 0);
    chk("full_after_pop_out", outstanding_o, 7);
    tick();
    chk("full_regrant_v", io_cmd_v_o, 1);
    chk("full_regrant_cmd", io_cmd_o, W'(64'hC0));
    chk("full_regrant_yumi", req_cmd_yumi_o, 2'b01);
    tick();
    req_cmd_v_i = '0;
    io_cmd_yumi_i = 1'b0;
    chk("full_refill_out", outstanding_o, 8);
    do_reset();
    issue(1, W'(64'hD1));
    issue(0, W'(64'hD0));
    issue(1, W'(64'hD2));
    chk("bp_out", outstanding_o, 3);
    req_resp_ready_i = 2'b01;
    io_resp_i = W'(64'hE0);
    io_resp_v_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_low", io_resp_ready_o, 0);
      chk("bp_resp_v", req_resp_v_o, 2'b10);
      tick();
    end
    chk("bp_out_held", outstanding_o, 3);
    req_resp_ready_i = 2'b11;
    resp(2'b10, W'(64'hE0));
    resp(2'b01, W'(64'hE1));
    resp(2'b10, W'(64'hE2));
    chk("bp_out_end", outstanding_o, 0);
    set_cmd(0, W'(64'hF0));
    req_cmd_v_i = 2'b01;
    tick();
    #1;
    chk("lock_granted", io_cmd_v_o, 1);
    hold_i = 1'b1;
    set_cmd(1, W'(64'hF1));
    req_cmd_v_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lock_v", io_cmd_v_o, 1);
      chk("lock_cmd", io_cmd_o, W'(64'hF0));
      chk("lock_no_yumi", req_cmd_yumi_o, 2'b00);
      tick();
    end
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("lock_yumi", req_cmd_yumi_o, 2'b01);
    tick();
    io_cmd_yumi_i = 1'b0;
    req_cmd_v_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_no_grant", io_cmd_v_o, 0);
      tick();
    end
    hold_i = 1'b0;
    tick();
    #1;
    chk("hold_release_v", io_cmd_v_o, 1);
    chk("hold_release_cmd", io_cmd_o, W'(64'hF1));
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("hold_release_yumi", req_cmd_yumi_o, 2'b10);
    tick();
    io_cmd_yumi_i = 1'b0;
    req_cmd_v_i = '0;
    chk("hold_out", outstanding_o, 2);
    do_reset();
    io_resp_i = W'(64'h77);
    io_resp_v_i = 1'b1;
    #1;
    chk("err_ready", io_resp_ready_o, 0);
    chk("err_resp_v", req_resp_v_o, 2'b00);
    chk("err_pre", err_o, 0);
    tick();
    chk("err_set", err_o, 1);
    chk("err_stalled", io_resp_ready_o, 0);
    io_resp_v_i = 1'b0;
    tick();
    tick();
    chk("err_sticky", err_o, 1);
    issue(0, W'(64'h1000));
    issue(0, W'(64'h1008));
    issue(0, W'(64'h1010));
    chk("mid_out", outstanding_o, 3);
    reset_n_i = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    reset_n_i = 1'b1;
    tick();
    chk("midrst_out_after", outstanding_o, 0);
    chk("midrst_idle_after", idle_o, 1);
    io_resp_v_i = 1'b1;
    #1;
    chk("late_resp_ready", io_resp_ready_o, 0);
    tick();
    chk("late_resp_err", err_o, 1);
    io_resp_v_i = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
